// File: rtl/reg_fwd_pkg.sv
// Shared types and default sizes for the register-operand forwarding mux.
package reg_fwd_pkg;

    localparam int unsigned FWD_WIDTH = 32;
    localparam int unsigned FWD_AW    = 5;
    localparam int unsigned FWD_DEPTH = 3;

    typedef struct packed {
        logic                 valid;
        logic [FWD_AW-1:0]    wa;
        logic [FWD_WIDTH-1:0] data;
        logic                 ready;
    } fwd_entry_t;

endpackage

// File: rtl/reg_fwd_sel.sv
// Per-read-port priority matcher: newest in-flight write to rd_addr wins.
// REG_FWD_BYPASS_EN selects full forwarding; otherwise interlock-only.
module reg_fwd_sel
    import reg_fwd_pkg::*;
#(
    parameter int unsigned WIDTH = FWD_WIDTH,
    parameter int unsigned AW    = FWD_AW,
    parameter int unsigned DEPTH = FWD_DEPTH
) (
    input  logic [DEPTH-1:0]            valid,
    input  logic [DEPTH-1:0][AW-1:0]    wa,
    input  logic [DEPTH-1:0][WIDTH-1:0] data,
    input  logic [DEPTH-1:0]            ready,
    input  logic                        rd_en,
    input  logic [AW-1:0]               rd_addr,
    input  logic [WIDTH-1:0]            rf_data,
    output logic [WIDTH-1:0]            rd_data,
    output logic                        stall
);

    logic             hit;
    logic             hit_ready;
    logic [WIDTH-1:0] hit_data;

    // Index 0 is the youngest write, so the first match found wins.
    always_comb begin
        hit       = 1'b0;
        hit_ready = 1'b0;
        hit_data  = '0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!hit && valid[k] && (wa[k] == rd_addr) && (rd_addr != '0)) begin
                hit       = 1'b1;
                hit_ready = ready[k];
                hit_data  = data[k];
            end
        end
    end

`ifdef REG_FWD_BYPASS_EN
    assign rd_data = (hit && hit_ready) ? hit_data : rf_data;
    assign stall   = rd_en && hit && !hit_ready;
`else
    logic unused_sel;
    assign unused_sel = ^{hit_data, hit_ready};
    assign rd_data    = rf_data;
    assign stall      = rd_en && hit;
`endif

endmodule

// File: rtl/reg_fwd_mux.sv
// Register-operand forwarding mux: DEPTH-entry shift pipeline of in-flight writes.
// REG_FWD_BYPASS_EN enables forwarding of filled results; otherwise interlock-only.
module reg_fwd_mux
    import reg_fwd_pkg::*;
#(
    parameter int unsigned WIDTH = FWD_WIDTH,
    parameter int unsigned AW    = FWD_AW,
    parameter int unsigned DEPTH = FWD_DEPTH,
    parameter int unsigned NRD   = 2
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   push_we,
    input  logic [AW-1:0]          push_wa,
    input  logic [DEPTH-1:0]       fill_valid,
    input  logic [DEPTH*WIDTH-1:0] fill_data,
    input  logic                   stall,
    input  logic                   flush,
    input  logic [NRD-1:0]         rd_en,
    input  logic [NRD*AW-1:0]      rd_addr,
    input  logic [NRD*WIDTH-1:0]   rf_data,
    output logic [NRD*WIDTH-1:0]   rd_data,
    output logic                   stall_req
);

    logic [DEPTH-1:0]            valid_q;
    logic [DEPTH-1:0]            ready_q;
    logic [DEPTH-1:0][AW-1:0]    wa_q;
    logic [DEPTH-1:0][WIDTH-1:0] data_q;

    logic [DEPTH-1:0] fill_hit;
    logic [NRD-1:0]   port_stall;
    logic             push_ok;

`ifdef REG_FWD_BYPASS_EN
    // First data wins; the retiring entry's fill has nowhere to go.
    assign fill_hit = fill_valid & valid_q & ~ready_q;
    logic unused_fill;
    assign unused_fill = ^{fill_hit[DEPTH-1], fill_data[DEPTH*WIDTH-1 -: WIDTH]};
`else
    assign fill_hit = '0;
    logic unused_fill;
    assign unused_fill = ^{fill_valid, fill_data};
`endif

    assign push_ok = push_we && (push_wa != '0) && !stall && !stall_req;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            valid_q <= '0;
            ready_q <= '0;
            wa_q    <= '0;
            data_q  <= '0;
        end else if (flush) begin
            valid_q <= '0;
            ready_q <= '0;
        end else begin
            valid_q[0] <= push_ok;
            wa_q[0]    <= push_wa;
            data_q[0]  <= '0;
            ready_q[0] <= 1'b0;
            for (int k = 1; k < DEPTH; k++) begin
                valid_q[k] <= valid_q[k-1];
                wa_q[k]    <= wa_q[k-1];
                if (fill_hit[k-1]) begin
                    data_q[k]  <= fill_data[(k-1)*WIDTH +: WIDTH];
                    ready_q[k] <= 1'b1;
                end else begin
                    data_q[k]  <= data_q[k-1];
                    ready_q[k] <= ready_q[k-1];
                end
            end
        end
    end

    for (genvar i = 0; i < NRD; i++) begin : g_rd
        reg_fwd_sel #(
            .WIDTH (WIDTH),
            .AW    (AW),
            .DEPTH (DEPTH)
        ) u_sel (
            .valid   (valid_q),
            .wa      (wa_q),
            .data    (data_q),
            .ready   (ready_q),
            .rd_en   (rd_en[i]),
            .rd_addr (rd_addr[i*AW +: AW]),
            .rf_data (rf_data[i*WIDTH +: WIDTH]),
            .rd_data (rd_data[i*WIDTH +: WIDTH]),
            .stall   (port_stall[i])
        );
    end

    assign stall_req = |port_stall;

endmodule

// File: tb/tb_reg_fwd_mux.sv
// Self-checking bench for reg_fwd_mux: directed scenarios plus random traffic
// against a queue-of-writes reference model. Follows REG_FWD_BYPASS_EN.
module tb_reg_fwd_mux;

    localparam int W  = 32;
    localparam int A  = 5;
    localparam int D  = 3;
    localparam int NR = 2;

    logic            clk = 1'b0;
    logic            reset;
    logic            push_we;
    logic [A-1:0]    push_wa;
    logic [D-1:0]    fill_valid;
    logic [D*W-1:0]  fill_data;
    logic            stall;
    logic            flush;
    logic [NR-1:0]   rd_en;
    logic [NR*A-1:0] rd_addr;
    logic [NR*W-1:0] rf_data;
    logic [NR*W-1:0] rd_data;
    logic            stall_req;

    reg_fwd_mux #(
        .WIDTH (W),
        .AW    (A),
        .DEPTH (D),
        .NRD   (NR)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .push_we    (push_we),
        .push_wa    (push_wa),
        .fill_valid (fill_valid),
        .fill_data  (fill_data),
        .stall      (stall),
        .flush      (flush),
        .rd_en      (rd_en),
        .rd_addr    (rd_addr),
        .rf_data    (rf_data),
        .rd_data    (rd_data),
        .stall_req  (stall_req)
    );

    always #5 clk = ~clk;

    // Reference model: in-flight writes with their age in cycles since push.
    typedef struct {
        int unsigned addr;
        logic [W-1:0] data;
        bit           has;
        int unsigned  age;
    } wr_t;

    wr_t          q[$];
    logic [W-1:0] exp_data[NR];
    logic         exp_sreq;
    int           n_tests = 0;
    int           n_fail  = 0;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic void model_eval();
        exp_sreq = 1'b0;
        for (int i = 0; i < NR; i++) begin
            int unsigned a    = rd_addr[i*A +: A];
            int          best = -1;
            for (int j = 0; j < q.size(); j++) begin
                if (a != 0 && q[j].addr == a && (best < 0 || q[j].age < q[best].age)) best = j;
            end
            exp_data[i] = rf_data[i*W +: W];
`ifdef REG_FWD_BYPASS_EN
            if (best >= 0 && q[best].has) exp_data[i] = q[best].data;
            if (best >= 0 && !q[best].has && rd_en[i]) exp_sreq = 1'b1;
`else
            if (best >= 0 && rd_en[i]) exp_sreq = 1'b1;
`endif
        end
    endfunction

    function automatic void model_edge();
        if (flush) begin
            q.delete();
            return;
        end
`ifdef REG_FWD_BYPASS_EN
        foreach (q[j]) begin
            if (fill_valid[q[j].age] && !q[j].has) begin
                q[j].has  = 1'b1;
                q[j].data = fill_data[q[j].age*W +: W];
            end
        end
`endif
        foreach (q[j]) q[j].age++;
        for (int j = q.size() - 1; j >= 0; j--) if (q[j].age >= D) q.delete(j);
        if (push_we && push_wa != 0 && !stall && !exp_sreq)
            q.push_back('{addr: push_wa, data: '0, has: 1'b0, age: 0});
    endfunction

    task automatic settle();
        #1;
        model_eval();
        check("rd_data0", rd_data[0 +: W], exp_data[0]);
        check("rd_data1", rd_data[W +: W], exp_data[1]);
        check("stall_req", {31'd0, stall_req}, {31'd0, exp_sreq});
    endtask

    task automatic tick();
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic idle();
        push_we    = 1'b0;
        push_wa    = '0;
        fill_valid = '0;
        fill_data  = '0;
        stall      = 1'b0;
        flush      = 1'b0;
        rd_en      = '0;
        rd_addr    = '0;
        rf_data    = '0;
    endtask

    task automatic set_rd(input int p, input logic en, input int a, input logic [W-1:0] rf);
        rd_en[p]         = en;
        rd_addr[p*A +: A] = A'(a);
        rf_data[p*W +: W] = rf;
    endtask

    task automatic set_fill(input int k, input logic [W-1:0] v);
        fill_valid[k]     = 1'b1;
        fill_data[k*W +: W] = v;
    endtask

    task automatic push(input int a);
        push_we = 1'b1;
        push_wa = A'(a);
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(negedge clk);
        reset = 1'b0;
        q.delete();

        // Reset state: no match, data straight from the register file.
        set_rd(0, 1'b1, 8, 32'h11);
        settle();
        check("reset_rd", rd_data[0 +: W], 32'h11);
        check("reset_stall", {31'd0, stall_req}, 32'd0);

`ifdef REG_FWD_BYPASS_EN
        // Single forward through E/M/W.
        push(8);
        tick();
        idle(); set_rd(0, 1'b1, 8, 32'h11); set_fill(0, 32'h5);
        settle();
        check("fill_same_cycle_stall", {31'd0, stall_req}, 32'd1);
        tick();
        idle(); set_rd(0, 1'b1, 8, 32'h11);
        settle();
        check("fwd_m", rd_data[0 +: W], 32'h5);
        check("fwd_m_stall", {31'd0, stall_req}, 32'd0);
        tick(); settle();
        check("fwd_w", rd_data[0 +: W], 32'h5);
        tick(); settle();
        check("retired", rd_data[0 +: W], 32'h11);

        // Load-use: stall until the late fill lands, D's push becomes a bubble.
        idle(); push(9);
        tick();
        idle(); push(3); set_rd(0, 1'b1, 9, 32'h90); set_rd(1, 1'b1, 3, 32'h33);
        settle();
        check("load_stall_e", {31'd0, stall_req}, 32'd1);
        tick();
        idle(); set_rd(0, 1'b1, 9, 32'h90); set_rd(1, 1'b1, 3, 32'h33); set_fill(1, 32'h99);
        settle();
        check("load_stall_m", {31'd0, stall_req}, 32'd1);
        check("bubble_no_match", rd_data[W +: W], 32'h33);
        tick();
        idle(); set_rd(0, 1'b1, 9, 32'h90);
        settle();
        check("load_fwd_w", rd_data[0 +: W], 32'h99);
        check("load_fwd_stall", {31'd0, stall_req}, 32'd0);
        idle(); repeat (3) tick();

        // Newest write wins.
        push(4);
        tick();
        idle(); push(4); set_fill(0, 32'hA);
        tick();
        idle(); set_fill(0, 32'hB);
        tick();
        idle(); set_rd(0, 1'b1, 4, 32'h40);
        settle();
        check("newest_wins", rd_data[0 +: W], 32'hB);
        idle(); repeat (3) tick();

        // $0 is never tracked.
        push(0);
        tick();
        idle(); set_fill(0, 32'h7); set_rd(0, 1'b1, 0, 32'h70);
        tick();
        idle(); set_rd(0, 1'b1, 0, 32'h70);
        settle();
        check("r0_data", rd_data[0 +: W], 32'h70);
        check("r0_stall", {31'd0, stall_req}, 32'd0);
        idle(); repeat (2) tick();
`else
        // Interlock-only: stall for every cycle the write is in flight.
        push(8);
        tick();
        for (int c = 0; c < 3; c++) begin
            idle(); set_rd(0, 1'b1, 8, 32'h11); set_fill(c, 32'h5);
            settle();
            check("ilk_stall", {31'd0, stall_req}, 32'd1);
            check("ilk_data", rd_data[0 +: W], 32'h11);
            tick();
        end
        idle(); set_rd(0, 1'b1, 8, 32'h11);
        settle();
        check("ilk_release", {31'd0, stall_req}, 32'd0);
        idle(); tick();
`endif

        // Flush beats a simultaneous push (and stall).
        push(6);
        tick();
        idle(); push(7);
        tick();
        idle(); push(2); flush = 1'b1; stall = 1'b1;
        tick();
        idle(); set_rd(0, 1'b1, 6, 32'h60); set_rd(1, 1'b1, 7, 32'h77);
        settle();
        check("flush_rd0", rd_data[0 +: W], 32'h60);
        check("flush_stall", {31'd0, stall_req}, 32'd0);
        set_rd(0, 1'b1, 2, 32'h22);
        settle();
        check("flush_push_dropped", {31'd0, stall_req}, 32'd0);

        // Asynchronous reset mid-operation.
        idle(); push(5);
        tick();
        idle(); set_rd(0, 1'b1, 5, 32'h55);
        settle();
        check("pre_reset_stall", {31'd0, stall_req}, 32'd1);
        reset = 1'b1;
        #1;
        q.delete();
        settle();
        check("async_reset_stall", {31'd0, stall_req}, 32'd0);
        @(negedge clk);
        reset = 1'b0;

        // Random traffic against the model.
        for (int n = 0; n < 500; n++) begin
            push_we    = ($urandom_range(0, 3) != 0);
            push_wa    = A'($urandom_range(0, 3));
            fill_valid = D'($urandom);
            for (int k = 0; k < D; k++) fill_data[k*W +: W] = $urandom;
            stall      = ($urandom_range(0, 7) == 0);
            flush      = ($urandom_range(0, 15) == 0);
            for (int p = 0; p < NR; p++)
                set_rd(p, 1'($urandom_range(0, 1)), $urandom_range(0, 3), $urandom);
            settle();
            tick();
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/reg_fwd_mux.md
# reg_fwd_mux

Parametrised register-operand forwarding mux for the pipelined MIPS core. Tracks every in-flight register write in a DEPTH-entry shift pipeline (index 0 = E, 1 = M, 2 = W for DEPTH=3). Each read port gets the newest in-flight value for its address, or the register-file value when no write to that address is in flight. A stall request is raised when the newest matching write has no data yet. It replaces the fixed 2-/3-input operand muxes with one block sized by parameters.

## Interface
- WIDTH, 32, data width
- AW, 5, register address width
- DEPTH, 3, tracked pipeline stages after D (≥2)
- NRD, 2, number of read ports
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-high; clears all entries
- push_we  in  1  instruction leaving D writes a register
- push_wa  in  AW  its destination address
- fill_valid  in  DEPTH  bit k: result of entry k is available this cycle
- fill_data  in  DEPTH*WIDTH  slice k: result for entry k
- stall  in  1  external stall (e.g. mult/div busy)
- flush  in  1  discard all in-flight entries
- rd_en  in  NRD  read port i uses its operand
- rd_addr  in  NRD*AW  read addresses
- rf_data  in  NRD*WIDTH  register-file read data
- rd_data  out  NRD*WIDTH  forwarded operand data
- stall_req  out  1  D must hold; a bubble enters index 0

## Operation
- Entry state: valid, wa, data, ready.
- Every edge: entry k moves to k+1; entry DEPTH-1 retires.
- Entry 0 loads {push_we, push_wa, ready=0} unless stall or stall_req is high; then it loads a bubble (valid=0).
- push_we=1 with push_wa=0 loads a bubble. $0 is never tracked.
- On the shift out of index k, fill_valid[k] writes fill_data[k] into the moving entry and sets ready=1. This only applies if entry k is valid and not already ready; otherwise the fill is ignored and the first data is kept.
- Match rules for read i:
  - A match is a valid entry with wa==rd_addr[i]. Address 0 never matches.
  - The lowest matching index wins.
  - Winner ready: rd_data[i] = winner's data. Winner not ready: rd_data[i] = rf_data[i].
  - No match: rd_data[i] = rf_data[i].
- stall_req = OR over i of (rd_en[i] && the winning match is not ready).
- rd_data and stall_req are combinational from current entries and inputs.
- flush: all entries become invalid on the edge. flush beats push and fill. stall_req is ignored that cycle for the push decision.

## Timing
- Reset: all entries invalid. stall_req=0 and rd_data=rf_data until the first push.
- A push at edge t sits at index k during cycle t+1+k.
- A fill at index k is visible at index k+1 in the next cycle, giving a 1-cycle forward latency.
- rd_data has zero-cycle latency from rd_addr and rf_data.
- A read in the same cycle as a fill at the winning index still sees the entry as not ready. stall_req is high for that cycle.
- Reset mid-operation clears immediately (asynchronous). Nothing is retained.
- Simultaneous stall and flush: flush wins, leaving all entries invalid.

## Configuration
- REG_FWD_BYPASS_EN defined: full forwarding as described above.
- REG_FWD_BYPASS_EN undefined (interlock-only):
  - rd_data = rf_data always.
  - stall_req = OR over i of (rd_en[i] && any match at any index, ready or not).
  - fill ports are ignored.
  - The register file must be write-before-read or the core must tolerate one extra stall cycle.

## Structure
- Shared package reg_fwd_pkg holds the entry typedef {valid, wa, data, ready} and default constants WIDTH/AW/DEPTH.
- One sub-module, reg_fwd_sel: a per-read-port priority matcher (address compare, lowest-index select, ready check), instantiated NRD times.

## Test plan
All scenarios use DEPTH=3, NRD=2, WIDTH=32.
- Reset, then rd_addr=8, rf_data=0x11 → rd_data=0x11, stall_req=0.
- Push wa=8. Next cycle fill_valid[0], data 0x5. Next cycle read 8 → rd_data=0x5, stall_req=0. After 2 more edges: rd_data=rf_data.
- Push load wa=9, fill at index 1 only. Read 9 with rd_en at index 0 → stall_req=1, and index 0 gets a bubble. At index 1 → still 1. Next cycle → forwards filled value, stall_req=0.
- Back-to-back pushes wa=4 (fill 0xA) then wa=4 (fill 0xB); read 4 → 0xB (newest wins).
- Push wa=0 with fill 0x7 → read 0 returns rf_data, never 0x7, no stall.
- flush with entries valid and a simultaneous push → all invalid next cycle, reads return rf_data.
- With REG_FWD_BYPASS_EN undefined: push wa=8 with fills; read 8 → stall_req=1 for 3 cycles, then 0 with rd_data=rf_data.
